// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the decode-stage register file.
package riscv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int ZERO_REG      = 0;

  // Address width needed to index nregs registers (at least one bit).
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_fwd_port.sv
// Single read-port resolver: picks the youngest available copy of a register
// (zero, EX forward, writeback bypass, array) and flags reads that must wait
// on a pending long-latency producer.
module regfile_fwd_port
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = addr_width(NREGS_DEFAULT)
) (
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] arr_word,
  input  logic            busy_bit,
  input  logic            fwd_valid,
  input  logic [AW-1:0]   fwd_addr,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd_data,
  output logic            unresolved
);

  logic is_zero;
  logic fwd_hit;
  logic wb_hit;

  assign is_zero = (rd_addr == AW'(ZERO_REG));
  assign fwd_hit = fwd_valid && (fwd_addr == rd_addr);
  assign wb_hit  = we && (wa == rd_addr);

  // Priority mux: the younger the producer, the higher its priority.
  always_comb begin
    rd_data = arr_word;
    if (is_zero) begin
      rd_data = '0;
    end else if (fwd_hit) begin
      rd_data = fwd_data;
    end else if (wb_hit) begin
      rd_data = wd;
    end
  end

  // A pending register is still usable when its value arrives on a bypass.
  always_comb begin
    unresolved = rd_en && !is_zero && busy_bit && !fwd_hit && !wb_hit;
  end

endmodule

// File: rtl/regfile_fwd.sv
// NREAD-port register file with write-first bypass, EX forwarding and a
// pending-write scoreboard that raises a decode stall.
// Optional macro REGFILE_FWD_PERF_EN adds a saturating stall_cycles counter.
module regfile_fwd
  import riscv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NREAD = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  fwd_valid,
  input  logic [AW-1:0]         fwd_addr,
  input  logic [XLEN-1:0]       fwd_data,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic                  stall,
  output logic [NREGS-1:0]      busy
`ifdef REGFILE_FWD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREAD-1:0] unres;
  logic             wr_ok;
  logic             set_ok;

  assign wr_ok  = we && (wa != AW'(ZERO_REG));
  assign set_ok = sb_set && (sb_addr != AW'(ZERO_REG));

  // Architectural array; register 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // Scoreboard next state: a new producer outranks a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wa] = 1'b0;
    end
    if (set_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    logic [AW-1:0] addr_g;
    assign addr_g = rd_addr[g*AW +: AW];

    regfile_fwd_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .rd_en      (rd_en[g]),
      .rd_addr    (addr_g),
      .arr_word   (mem[addr_g]),
      .busy_bit   (busy_q[addr_g]),
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .rd_data    (rd_data[g*XLEN +: XLEN]),
      .unresolved (unres[g])
    );
  end

  assign stall = |unres;

`ifdef REGFILE_FWD_PERF_EN
  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Parametrised successor to the single-bypass register read stage: an NREAD-port register file with a synchronous write port.
- Resolves each read combinationally from three sources: a younger-stage forward, the writeback-in-flight bypass, and the array.
- Contains a pending-write scoreboard for long-latency producers (loads, multi-cycle ops) and raises a decode stall when a read cannot yet be satisfied.
- Sits in the decode stage and replaces the reg_file plus read_from_reg pairing.

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of architectural registers (power of two); register 0 is hardwired zero.
- NREAD, 2, number of read ports.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NREAD  per-port read valid; a disabled port never stalls.
- rd_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW].
- rd_data  out  NREAD*XLEN  packed resolved read data.
- we  in  1  writeback write enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- fwd_valid  in  1  younger-stage (EX) result valid this cycle.
- fwd_addr  in  AW  EX destination.
- fwd_data  in  XLEN  EX result.
- sb_set  in  1  issue of a long-latency producer this cycle.
- sb_addr  in  AW  destination marked pending by sb_set.
- stall  out  1  at least one enabled read is unresolved.
- busy  out  NREGS  scoreboard vector (bit 0 always 0).

Behaviour:
- Array: write on rising clk when we && wa!=0. Writes to register 0 are dropped.
- Reset: on rst at a rising edge, every array entry and every busy bit is cleared to 0. A write or sb_set presented in the same cycle as rst is ignored. After reset, stall=0 and every read returns 0.
- Read resolution per port, combinational, zero latency, in priority order:
  - addr==0 → 0.
  - fwd_valid && fwd_addr==addr → fwd_data.
  - we && wa==addr → wd (write-first bypass).
  - otherwise → array[addr].
- Scoreboard, per register r≠0, next state:
  - sb_set && sb_addr==r → 1.
  - else we && wa==r → 0.
  - else hold.
  - Set wins over a simultaneous clear on the same register, because the new producer is younger.
  - sb_set to register 0 is ignored.
- Stall, per port: unresolved = rd_en && addr!=0 && busy[addr] && !(fwd_valid&&fwd_addr==addr) && !(we&&wa==addr).
  - stall = OR over ports; purely combinational from current busy and inputs.
  - A writeback that clears busy in the same cycle satisfies the read via bypass, so no stall is raised.
- The block does not hold its own inputs. Upstream re-presents the same addresses while stall=1. The scoreboard continues updating during stall.
- Duplicate addresses across ports resolve identically. Every port resolves independently under the same rules.
- A reset mid-stall clears all busy bits, so stall drops on the cycle after reset.

Optional Feature:
- REGFILE_FWD_PERF_EN.
- Defined: adds output stall_cycles [31:0], a counter incremented each cycle stall=1. It is cleared by rst and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg: XLEN default, register-count constant, AW derivation helper, and named constant ZERO_REG=0.
- One natural sub-module, regfile_fwd_port: a single-port resolver that computes the mux priority and the unresolved flag from the array word, busy bit, forward and writeback inputs. It is instantiated NREAD times by a generate loop. The array and scoreboard stay in the top.

Test Plan:
- Basic read: write x4=1000, x5=700 on consecutive cycles; read ports 0/1 at 4/5 → rd_data 1000/700, stall=0.
- Bypass priority: x4=1000 in array; same cycle we wa=4 wd=400 and fwd_valid fwd_addr=4 fwd_data=555 → port 0 reads 555. Drop fwd → 400. Next cycle with nothing presented → 400 from array.
- x0: we wa=0 wd=123, fwd to 0 with 77, busy set on 0 → reads of x0 return 0, stall=0, busy[0]=0.
- Scoreboard: sb_set sb_addr=7; next cycle read x7 → stall=1, held 3 cycles. Then we wa=7 wd=42 → same cycle stall=0, rd=42. Next cycle busy[7]=0.
- Set/clear collision: busy[9]=1; same cycle sb_set 9 and we wa=9 wd=5 → busy[9] stays 1. Array x9=5. A following read of x9 stalls.
- Reset mid-stall: busy[3]=1 with read of x3 stalling; assert rst one cycle → busy=0, stall=0, x3 reads 0. With REGFILE_FWD_PERF_EN, stall_cycles reads 0 after reset and then counts exact stall cycles.
